// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: turns each accepted single-cycle request pulse into a burst
// of strobes separated by idle gap cycles, with busy/done/drop status.
// Build option: define PULSE_BURST_PENDING_EN to queue requests that arrive
// mid-burst in a saturating pending counter; without it they are dropped.
module pulse_burst_gen #(
    parameter int LEN_W  = 4,
    parameter int GAP_W  = 4,
    parameter int PEND_W = 3
) (
    input  logic             fast_clk,
    input  logic             rst,
    input  logic             pulse_fast_in,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [GAP_W-1:0] gap_len,
    output logic             strobe_out,
    output logic             busy,
    output logic             burst_done,
    output logic             drop
);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] strobeCnt_q, strobeCnt_d;
    logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
    logic [GAP_W-1:0] gapLen_q, gapLen_d;

    logic strobe_q, strobe_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic drop_q, drop_d;

    logic reqDuringBurst;
    logic startBurst;

    // Degenerate widths would leave counters with no bits to count in.
    if (LEN_W < 1 || GAP_W < 1 || PEND_W < 1) begin : gParamCheck
        $error("pulse_burst_gen: LEN_W, GAP_W and PEND_W must all be at least 1");
    end

    assign reqDuringBurst = pulse_fast_in && (state_q != IDLE);

`ifdef PULSE_BURST_PENDING_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pending_q, pending_d;
    logic              pendingNonZero;

    assign pendingNonZero = (pending_q != '0);
    assign startBurst     = pulse_fast_in || pendingNonZero;

    // Pending queue: a mid-burst request is queued unless full; an idle start
    // fed only by the queue consumes one entry, while a fresh pulse coinciding
    // with a queued start takes that entry's place, leaving the count as is.
    always_comb begin
        pending_d = pending_q;
        if (state_q != IDLE) begin
            if (pulse_fast_in && (pending_q != PEND_MAX)) begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (pendingNonZero && !pulse_fast_in) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    // Pending counter register.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign drop_d = reqDuringBurst && (pending_q == PEND_MAX);
`else
    assign startBurst = pulse_fast_in;
    assign drop_d     = reqDuringBurst;
`endif

    // State register: burst sequencing state plus the latched burst parameters.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            strobeCnt_q <= '0;
            gapCnt_q    <= '0;
            gapLen_q    <= '0;
        end else begin
            state_q     <= state_d;
            strobeCnt_q <= strobeCnt_d;
            gapCnt_q    <= gapCnt_d;
            gapLen_q    <= gapLen_d;
        end
    end

    // Next-state logic: strobeCnt holds the strobes still owed including the
    // current one, gapCnt the idle cycles left before the next strobe.
    always_comb begin
        state_d     = state_q;
        strobeCnt_d = strobeCnt_q;
        gapCnt_d    = gapCnt_q;
        gapLen_d    = gapLen_q;
        unique case (state_q)
            IDLE: begin
                if (startBurst) begin
                    state_d     = STROBE;
                    strobeCnt_d = (burst_len == '0) ? LEN_W'(1) : burst_len;
                    gapLen_d    = gap_len;
                end
            end
            STROBE: begin
                if (strobeCnt_q == LEN_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    strobeCnt_d = strobeCnt_q - LEN_W'(1);
                    if (gapLen_q != '0) begin
                        state_d  = GAP;
                        gapCnt_d = gapLen_q;
                    end
                end
            end
            GAP: begin
                if (gapCnt_q == GAP_W'(1)) begin
                    state_d = STROBE;
                end else begin
                    gapCnt_d = gapCnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        strobe_d = (state_d == STROBE);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == STROBE) && (strobeCnt_d == LEN_W'(1));
    end

    // Output registers.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign strobe_out = strobe_q;
    assign busy       = busy_q;
    assign burst_done = done_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// tb_pulse_burst_gen: directed and randomized checks of pulse_burst_gen against
// a cycle-indexed behavioural model (follows PULSE_BURST_PENDING_EN as well).
module tb_pulse_burst_gen;

    localparam int LEN_W    = 4;
    localparam int GAP_W    = 4;
    localparam int PEND_W   = 2;
    localparam int PEND_MAX = (1 << PEND_W) - 1;

    logic             fast_clk = 1'b0;
    logic             rst = 1'b1;
    logic             pulse_fast_in = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic [GAP_W-1:0] gap_len = '0;
    logic             strobe_out;
    logic             busy;
    logic             burst_done;
    logic             drop;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;

    // Model: the current burst is described by its accept cycle and shape.
    bit mActive = 1'b0;
    int mStart = 0;
    int mGap = 0;
    int mLast = 0;
    int mPending = 0;
    int mDropCycle = -1;

    pulse_burst_gen #(
        .LEN_W (LEN_W),
        .GAP_W (GAP_W),
        .PEND_W(PEND_W)
    ) dut (
        .fast_clk     (fast_clk),
        .rst          (rst),
        .pulse_fast_in(pulse_fast_in),
        .burst_len    (burst_len),
        .gap_len      (gap_len),
        .strobe_out   (strobe_out),
        .busy         (busy),
        .burst_done   (burst_done),
        .drop         (drop)
    );

    always #5 fast_clk = ~fast_clk;

    always @(posedge fast_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got %0b, expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic p, input int l, input int g);
        @(posedge fast_clk);
        #1;
        pulse_fast_in = p;
        burst_len     = l[LEN_W-1:0];
        gap_len       = g[GAP_W-1:0];
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0);
    endtask

    // Asserts reset between edges and expects every output to clear at once.
    task automatic asyncReset(input string tag);
        @(posedge fast_clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput({tag, "_strobe"}, strobe_out, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_done"}, burst_done, 1'b0);
        checkOutput({tag, "_drop"}, drop, 1'b0);
        @(posedge fast_clk);
        #1;
        rst = 1'b0;
        pulse_fast_in = 1'b0;
    endtask

    // Every cycle: compare outputs with the model, then let the model absorb
    // this cycle's inputs to decide what later cycles must show.
    always @(negedge fast_clk) begin : compareProc
        bit inBurst;
        bit expStrobe;
        int n;
        if (rst) begin
            checkOutput("model_strobe", strobe_out, 1'b0);
            checkOutput("model_busy", busy, 1'b0);
            checkOutput("model_done", burst_done, 1'b0);
            checkOutput("model_drop", drop, 1'b0);
            mActive    = 1'b0;
            mPending   = 0;
            mDropCycle = -1;
        end else begin
            inBurst   = mActive && (cyc >= mStart + 1) && (cyc <= mLast);
            expStrobe = inBurst && (((cyc - mStart - 1) % (mGap + 1)) == 0);
            checkOutput("model_strobe", strobe_out, expStrobe);
            checkOutput("model_busy", busy, inBurst);
            checkOutput("model_done", burst_done, inBurst && (cyc == mLast));
            checkOutput("model_drop", drop, mDropCycle == cyc);
            if (inBurst) begin
                if (pulse_fast_in) begin
`ifdef PULSE_BURST_PENDING_EN
                    if (mPending < PEND_MAX) mPending++;
                    else mDropCycle = cyc + 1;
`else
                    mDropCycle = cyc + 1;
`endif
                end
            end else if (pulse_fast_in || mPending > 0) begin
                if (!pulse_fast_in) mPending--;
                n       = (burst_len == 0) ? 1 : int'(burst_len);
                mActive = 1'b1;
                mStart  = cyc;
                mGap    = int'(gap_len);
                mLast   = mStart + 1 + (n - 1) * (mGap + 1);
            end
        end
    end

    initial begin
        logic [8:1]  bS, bB, bD;
        logic [3:1]  zS;
        logic [6:1]  fS, fB, fD;
        logic [12:1] dP, dS, dD, dB;
        logic [26:1] qS, qD, qB, qR;

        // Reset values and quiet after release.
        repeat (3) @(posedge fast_clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge fast_clk);
            checkOutput("rst_strobe", strobe_out, 1'b0);
            checkOutput("rst_busy", busy, 1'b0);
        end

        // Basic burst: 3 strobes, gap 2; inputs change mid-burst to no effect.
        bS = 8'b01001001;
        bB = 8'b01111111;
        bD = 8'b01000000;
        applyStimulus(1'b1, 3, 2);
        for (int off = 1; off <= 8; off++) begin
            applyStimulus(1'b0, 7, 0);
            @(negedge fast_clk);
            checkOutput("basic_strobe", strobe_out, bS[off]);
            checkOutput("basic_busy", busy, bB[off]);
            checkOutput("basic_done", burst_done, bD[off]);
        end
        idleCycles(2);

        // Zero length and gap: one strobe; then 4 back-to-back strobes.
        zS = 3'b001;
        applyStimulus(1'b1, 0, 0);
        for (int off = 1; off <= 3; off++) begin
            applyStimulus(1'b0, 0, 0);
            @(negedge fast_clk);
            checkOutput("zero_strobe", strobe_out, zS[off]);
            checkOutput("zero_done", burst_done, zS[off]);
            checkOutput("zero_busy", busy, zS[off]);
        end
        fS = 6'b001111;
        fB = 6'b001111;
        fD = 6'b001000;
        applyStimulus(1'b1, 4, 0);
        for (int off = 1; off <= 6; off++) begin
            applyStimulus(1'b0, 4, 0);
            @(negedge fast_clk);
            checkOutput("b2b_strobe", strobe_out, fS[off]);
            checkOutput("b2b_busy", busy, fB[off]);
            checkOutput("b2b_done", burst_done, fD[off]);
        end
        idleCycles(2);

`ifdef PULSE_BURST_PENDING_EN
        // Four requests during a 3-strobe burst: three queue, one drops.
        qR = 26'b000_00000_0_00000_0_00000_0_01111;
        qS = 26'b000_10101010101010101010101;
        qD = 26'b000_1_00000_1_00000_1_00000_1_0000;
        qB = 26'b000_11111_0_11111_0_11111_0_11111;
        applyStimulus(1'b1, 3, 1);
        for (int off = 1; off <= 26; off++) begin
            applyStimulus(qR[off], 3, 1);
            @(negedge fast_clk);
            checkOutput("queue_strobe", strobe_out, qS[off]);
            checkOutput("queue_done", burst_done, qD[off]);
            checkOutput("queue_busy", busy, qB[off]);
            checkOutput("queue_drop", drop, off == 5);
        end
`else
        // Requests during GAP and on the last strobe are both dropped.
        dP = 12'b000001000010;
        dS = 12'b000001001001;
        dD = 12'b000010000100;
        dB = 12'b000001111111;
        applyStimulus(1'b1, 3, 2);
        for (int off = 1; off <= 12; off++) begin
            applyStimulus(dP[off], 3, 2);
            @(negedge fast_clk);
            checkOutput("drop_strobe", strobe_out, dS[off]);
            checkOutput("drop_drop", drop, dD[off]);
            checkOutput("drop_busy", busy, dB[off]);
        end
`endif
        idleCycles(2);

        // Reset during GAP of a 5-strobe burst, then a fresh 1-cycle-latency burst.
        applyStimulus(1'b1, 5, 2);
        applyStimulus(1'b0, 5, 2);
        @(negedge fast_clk);
        checkOutput("mid_first_strobe", strobe_out, 1'b1);
        @(posedge fast_clk);
        #2;
        checkOutput("mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("mid_async_busy", busy, 1'b0);
        checkOutput("mid_async_strobe", strobe_out, 1'b0);
        @(posedge fast_clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge fast_clk);
            checkOutput("mid_no_strobe", strobe_out, 1'b0);
            checkOutput("mid_no_done", burst_done, 1'b0);
            applyStimulus(1'b0, 5, 2);
        end
        applyStimulus(1'b1, 2, 0);
        applyStimulus(1'b0, 2, 0);
        @(negedge fast_clk);
        checkOutput("fresh_strobe", strobe_out, 1'b1);
        checkOutput("fresh_busy", busy, 1'b1);
        idleCycles(4);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                asyncReset("rand_rst");
            end else begin
                applyStimulus($urandom_range(0, 99) < 25, $urandom_range(0, 5),
                              $urandom_range(0, 3));
            end
        end
        idleCycles(40);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
